heartbeat_monitor: RTL and testbench

Receive-side checker for the heartbeat LED signal. It synchronises an incoming heartbeat square wave and measures each half-period between edges. It classifies every measured half-period as good, fast or slow, and declares loss of heartbeat on timeout. It sits beside the LED mode drivers as a self-test and loopback monitor, running on the same slow system clock.

---
 rtl/heartbeat_monitor_if.sv | 27 ++
 rtl/heartbeat_monitor.sv | 144 ++++++++++++++
 tb/tb_heartbeat_monitor.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor bus: raw heartbeat in, soft clear in,
// lock/fault/loss status and half-period measurement out.
interface heartbeat_monitor_if #(
    parameter int CNT_W = 10
);
    logic             hb_in;
    logic             clear;
    logic             hb_ok;
    logic             hb_lost;
    logic             hb_fast;
    logic             hb_slow;
    logic             edge_seen;
    logic [7:0]       edge_cnt;
    logic [CNT_W-1:0] last_half;

    modport master (
        output hb_in, clear,
        input  hb_ok, hb_lost, hb_fast, hb_slow,
        input  edge_seen, edge_cnt, last_half
    );

    modport slave (
        input  hb_in, clear,
        output hb_ok, hb_lost, hb_fast, hb_slow,
        output edge_seen, edge_cnt, last_half
    );
endinterface

// File: rtl/heartbeat_monitor.sv
// Heartbeat receive checker: synchronises hb_in, times half-periods
// and tracks acquisition, lock, fault and loss of the heartbeat.
module heartbeat_monitor #(
    parameter int CNT_W        = 10,
    parameter int NOMINAL_HALF = 300,
    parameter int TOL          = 30,
    parameter int TIMEOUT      = 600,
    parameter int LOCK_N       = 2
) (
    input logic                clk,
    input logic                rst_n,
    heartbeat_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ACQ, LOCKED, FAULT, LOST
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0] WIN_LO = (CNT_W+1)'(NOMINAL_HALF - TOL);
    localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(NOMINAL_HALF + TOL);
    localparam logic [CNT_W:0] TMO = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
    localparam logic [2:0] RUN_LOCK = 3'(LOCK_N);

    state_t           state_q, state_d;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] half_q, half_d;
    logic [2:0]       run_q, run_d, run_inc;
    logic             fast_q, fast_d;
    logic             slow_q, slow_d;
    logic             seen_q, seen_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             edge_det, tmo, good, short_half;
    logic [CNT_W:0]   interval;

    // Three-flop chain: s1/s2 resolve metastability, s3 gives edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.hb_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            run_q   <= '0;
            fast_q  <= 1'b0;
            slow_q  <= 1'b0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            run_q   <= run_d;
            fast_q  <= fast_d;
            slow_q  <= slow_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        edge_det   = s2 ^ s3;
        interval   = {1'b0, half_q} + ONE;
        tmo        = !edge_det && (interval == TMO);
        good       = (interval >= WIN_LO) && (interval <= WIN_HI);
        short_half = interval < WIN_LO;
        run_inc    = (state_q == FAULT) ? 3'd1 : run_q + 3'd1;

        state_d = state_q;
        run_d   = run_q;
        fast_d  = fast_q;
        slow_d  = slow_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        seen_d  = edge_det;
        if (edge_det)
            half_d = '0;
        else if (half_q == CNT_MAX)
            half_d = half_q;
        else
            half_d = half_q + CNT_W'(1);

        if (bus.clear) begin
            state_d = IDLE;
            run_d   = '0;
            fast_d  = 1'b0;
            slow_d  = 1'b0;
            cnt_d   = '0;
            last_d  = '0;
            seen_d  = 1'b0;
            half_d  = '0;
        end else if (edge_det) begin
            cnt_d = cnt_q + 8'd1;
            unique case (state_q)
                IDLE, LOST: begin
                    state_d = ACQ;
                    run_d   = '0;
                end
                ACQ, LOCKED, FAULT: begin
                    last_d = interval[CNT_W] ? CNT_MAX
                                             : interval[CNT_W-1:0];
                    if (!good) begin
                        state_d = FAULT;
                        run_d   = '0;
                        fast_d  = short_half;
                        slow_d  = !short_half;
                    end else if (state_q != LOCKED) begin
                        run_d = run_inc;
                        if (run_inc >= RUN_LOCK) begin
                            state_d = LOCKED;
                            fast_d  = 1'b0;
                            slow_d  = 1'b0;
                        end else begin
                            state_d = ACQ;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo && state_q != LOST) begin
            state_d = LOST;
            run_d   = '0;
        end
    end

    assign bus.hb_ok     = (state_q == LOCKED);
    assign bus.hb_lost   = (state_q == LOST);
    assign bus.hb_fast   = fast_q;
    assign bus.hb_slow   = slow_q;
    assign bus.edge_seen = seen_q;
    assign bus.edge_cnt  = cnt_q;
    assign bus.last_half = last_q;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: directed and random half-periods
// compared against an interval-level model of lock/fault/loss rules.
module tb_heartbeat_monitor;
    localparam int CNT_W  = 10;
    localparam int NOM    = 300;
    localparam int TOL    = 30;
    localparam int TMO    = 600;
    localparam int LOCK_N = 2;
    localparam int SW     = 13 + CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    heartbeat_monitor_if #(.CNT_W(CNT_W)) bus ();

    heartbeat_monitor #(
        .CNT_W        (CNT_W),
        .NOMINAL_HALF (NOM),
        .TOL          (TOL),
        .TIMEOUT      (TMO),
        .LOCK_N       (LOCK_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: m_ref means the next edge is only a timing reference
    bit m_ref, m_lock, m_lost, m_fast, m_slow;
    int m_run, m_cnt, m_last;

    function automatic void model_reset();
        m_ref  = 1'b1;
        m_lock = 1'b0;
        m_lost = 1'b0;
        m_fast = 1'b0;
        m_slow = 1'b0;
        m_run  = 0;
        m_cnt  = 0;
        m_last = 0;
    endfunction

    function automatic void model_lost();
        m_ref  = 1'b1;
        m_lost = 1'b1;
        m_lock = 1'b0;
        m_run  = 0;
    endfunction

    function automatic void model_edge(input int n);
        m_cnt = (m_cnt + 1) % 256;
        if (m_ref) begin
            m_ref  = 1'b0;
            m_lost = 1'b0;
            m_run  = 0;
        end else begin
            m_last = (n > 1023) ? 1023 : n;
            if (n >= NOM - TOL && n <= NOM + TOL) begin
                if (!m_lock) begin
                    m_run++;
                    if (m_run >= LOCK_N) begin
                        m_lock = 1'b1;
                        m_fast = 1'b0;
                        m_slow = 1'b0;
                    end
                end
            end else begin
                m_lock = 1'b0;
                m_run  = 0;
                m_fast = (n < NOM - TOL);
                m_slow = !m_fast;
            end
        end
    endfunction

    task automatic observe(input int n, input string tag);
        logic [SW-1:0] got, exp;
        repeat (3) @(negedge clk);
        model_edge(n);
        got = {bus.edge_seen, bus.hb_ok, bus.hb_lost, bus.hb_fast,
               bus.hb_slow, bus.edge_cnt, bus.last_half};
        exp = {1'b1, m_lock, m_lost, m_fast, m_slow,
               8'(m_cnt), CNT_W'(m_last)};
        total++;
        if (got !== exp)
            $display("FAIL %s: status %h, expected %h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic hb_toggle(input int n, input int pre, input string tag);
        repeat (n - 3 - pre) @(negedge clk);
        bus.hb_in = ~bus.hb_in;
        observe(n, tag);
    endtask

    task automatic test_reset();
        logic [SW-2:0] st;
        bus.hb_in = 1'b0;
        bus.clear = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        st = {bus.hb_ok, bus.hb_lost, bus.hb_fast, bus.hb_slow,
              bus.edge_cnt, bus.last_half};
        total++;
        if (st !== '0 || bus.edge_seen !== 1'b0)
            $display("FAIL reset: status %h seen %b, expected 0",
                     st, bus.edge_seen);
        else
            passed++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_lock();
        hb_toggle(300, 0, "lock_ref");
        hb_toggle(300, 0, "lock_e2");
        hb_toggle(300, 0, "lock_e3");
        @(negedge clk);
        total++;
        if (bus.edge_seen !== 1'b0 || bus.hb_ok !== 1'b1)
            $display("FAIL lock_pulse: seen %b ok %b, expected 0 1",
                     bus.edge_seen, bus.hb_ok);
        else
            passed++;
    endtask

    task automatic test_fault_recover();
        hb_toggle(260, 1, "fault_260");
        total++;
        if (bus.hb_fast !== 1'b1 || bus.last_half !== 10'd260)
            $display("FAIL fault_260: fast %b last %0d, expected 1 260",
                     bus.hb_fast, bus.last_half);
        else
            passed++;
        hb_toggle(300, 0, "recover_1");
        hb_toggle(300, 0, "recover_2");
        total++;
        if (bus.hb_ok !== 1'b1 || bus.hb_fast !== 1'b0)
            $display("FAIL recover: ok %b fast %b, expected 1 0",
                     bus.hb_ok, bus.hb_fast);
        else
            passed++;
    endtask

    task automatic test_window();
        hb_toggle(330, 0, "win_330");
        hb_toggle(270, 0, "win_270");
        total++;
        if (bus.hb_ok !== 1'b1)
            $display("FAIL win_inside: ok %b, expected 1", bus.hb_ok);
        else
            passed++;
        hb_toggle(331, 0, "win_331");
        total++;
        if (bus.hb_slow !== 1'b1 || bus.hb_ok !== 1'b0)
            $display("FAIL win_331: slow %b ok %b, expected 1 0",
                     bus.hb_slow, bus.hb_ok);
        else
            passed++;
        hb_toggle(300, 0, "win_relock_a");
        hb_toggle(300, 0, "win_relock_b");
        hb_toggle(269, 0, "win_269");
        total++;
        if (bus.hb_fast !== 1'b1 || bus.hb_slow !== 1'b0)
            $display("FAIL win_269: fast %b slow %b, expected 1 0",
                     bus.hb_fast, bus.hb_slow);
        else
            passed++;
        hb_toggle(300, 0, "win_relock_c");
        hb_toggle(300, 0, "win_relock_d");
    endtask

    task automatic test_edge_at_timeout();
        hb_toggle(TMO, 0, "tmo_edge_600");
        total++;
        if (bus.hb_slow !== 1'b1 || bus.hb_lost !== 1'b0)
            $display("FAIL tmo_edge: slow %b lost %b, expected 1 0",
                     bus.hb_slow, bus.hb_lost);
        else
            passed++;
        hb_toggle(300, 0, "tmo_relock_a");
        hb_toggle(300, 0, "tmo_relock_b");
    endtask

    task automatic test_loss();
        repeat (TMO - 1) @(negedge clk);
        total++;
        if (bus.hb_lost !== 1'b0)
            $display("FAIL loss_early: lost %b, expected 0", bus.hb_lost);
        else
            passed++;
        repeat (2) @(negedge clk);
        total++;
        if (bus.hb_lost !== 1'b1 || bus.hb_ok !== 1'b0)
            $display("FAIL loss: lost %b ok %b, expected 1 0",
                     bus.hb_lost, bus.hb_ok);
        else
            passed++;
        model_lost();
        hb_toggle(300, 0, "lost_ref");
        total++;
        if (bus.hb_lost !== 1'b0)
            $display("FAIL lost_exit: lost %b, expected 0", bus.hb_lost);
        else
            passed++;
        hb_toggle(300, 0, "lost_relock_a");
        hb_toggle(300, 0, "lost_relock_b");
    endtask

    task automatic test_clear();
        logic [SW-1:0] st;
        hb_toggle(300, 0, "clr_locked");
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_reset();
        st = {bus.edge_seen, bus.hb_ok, bus.hb_lost, bus.hb_fast,
              bus.hb_slow, bus.edge_cnt, bus.last_half};
        total++;
        if (st !== '0)
            $display("FAIL clear: status %h, expected 0", st);
        else
            passed++;
        // Clear asserted during the edge-detect cycle must swallow the edge
        repeat (296) @(negedge clk);
        bus.hb_in = ~bus.hb_in;
        repeat (2) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        total++;
        if (bus.edge_seen !== 1'b0 || bus.edge_cnt !== 8'd0)
            $display("FAIL clear_prio: seen %b cnt %0d, expected 0 0",
                     bus.edge_seen, bus.edge_cnt);
        else
            passed++;
        hb_toggle(300, 0, "clr_ref");
        hb_toggle(300, 0, "clr_e2");
        hb_toggle(300, 0, "clr_e3");
    endtask

    task automatic test_random();
        int cls, n;
        int bnd [5];
        bnd = '{269, 270, 330, 331, 600};
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 9);
            if (cls <= 5)
                n = $urandom_range(270, 330);
            else if (cls <= 7)
                n = $urandom_range(20, 269);
            else if (cls == 8)
                n = $urandom_range(331, 600);
            else
                n = bnd[$urandom_range(0, 4)];
            hb_toggle(n, 0, $sformatf("rand%0d_n%0d", i, n));
        end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] st;
        hb_toggle(300, 0, "mid_pre_a");
        hb_toggle(300, 0, "mid_pre_b");
        if (bus.hb_in == 1'b0)
            hb_toggle(300, 0, "mid_pre_c");
        total++;
        if (bus.hb_ok !== 1'b1 || bus.hb_in !== 1'b1)
            $display("FAIL mid_setup: ok %b hb_in %b, expected 1 1",
                     bus.hb_ok, bus.hb_in);
        else
            passed++;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        st = {bus.edge_seen, bus.hb_ok, bus.hb_lost, bus.hb_fast,
              bus.hb_slow, bus.edge_cnt, bus.last_half};
        total++;
        if (st !== '0)
            $display("FAIL async_reset: status %h, expected 0", st);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        observe(0, "spurious_ref");
        hb_toggle(300, 0, "post_rst_e2");
        total++;
        if (bus.hb_ok !== 1'b0)
            $display("FAIL post_rst_early: ok %b, expected 0", bus.hb_ok);
        else
            passed++;
        hb_toggle(300, 0, "post_rst_e3");
        total++;
        if (bus.hb_ok !== 1'b1)
            $display("FAIL post_rst_lock: ok %b, expected 1", bus.hb_ok);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_fault_recover();
        test_window();
        test_edge_at_timeout();
        test_loss();
        test_clear();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
